// File: rtl/squeeze_serializer.sv
// Squeeze serializer: turns a squeezed Keccak rate block into a stream of
// 64-bit words, trimming the final word to the number of output bits owed.
module squeeze_serializer #(
  parameter int WORD_W        = 64,
  parameter int RATE_SHAKE128 = 1344
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     block_valid,
  output logic                     block_ready,
  input  logic [RATE_SHAKE128-1:0] rate_block,
  input  logic [1:0]               operation_mode,
  input  logic [31:0]              output_size,
  input  logic                     last_block,
  output logic [WORD_W-1:0]        data_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic                     data_out_last,
  output logic [6:0]               data_out_bits,
  output logic                     mode_error
);

  // Mode encodings shared with the permutation stage.
  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state;
  logic [RATE_SHAKE128-1:0] buffer;
  logic [31:0]              rem_bits;
  logic [4:0]               word_cnt;
  logic                     last_flag;

  logic                     mode_ok;
  logic [4:0]               rate_words;
  logic [32:0]              words_needed;
  logic [4:0]               load_cnt;
  logic                     accept;
  logic                     send_hs;
  logic                     rem_full;
  logic [WORD_W-1:0]        keep_mask;

  // Block acceptance: word count to load and the handshake conditions.
  always_comb begin
    mode_ok      = (operation_mode == SHAKE128_MODE_VEC) ||
                   (operation_mode == SHAKE256_MODE_VEC);
    rate_words   = (operation_mode == SHAKE256_MODE_VEC) ? 5'd17 : 5'd21;
    words_needed = ({1'b0, output_size} + 33'd63) >> 6;
    load_cnt     = (words_needed > {28'd0, rate_words}) ? rate_words
                                                        : words_needed[4:0];
    send_hs      = (state == SEND) && data_out_ready;
    block_ready  = !rst && ((state == IDLE) || (send_hs && (word_cnt == 5'd1)));
    accept       = block_valid && block_ready;
  end

  // Output word view: top of the buffer, trimmed to the bits still owed.
  always_comb begin
    rem_full       = (rem_bits >= 32'd64);
    keep_mask      = rem_full ? {WORD_W{1'b1}} : ~({WORD_W{1'b1}} >> rem_bits[5:0]);
    data_out_valid = !rst && (state == SEND);
    data_out       = '0;
    data_out_bits  = 7'd0;
    data_out_last  = 1'b0;
    if (data_out_valid) begin
      data_out      = buffer[RATE_SHAKE128-1 -: WORD_W] & keep_mask;
      data_out_bits = rem_full ? 7'd64 : {1'b0, rem_bits[5:0]};
      data_out_last = last_flag && (word_cnt == 5'd1);
    end
  end

  // FSM: load on accept, shift one word per handshake, reload back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buffer     <= '0;
      rem_bits   <= 32'd0;
      word_cnt   <= 5'd0;
      last_flag  <= 1'b0;
      mode_error <= 1'b0;
    end else begin
      mode_error <= accept && !mode_ok;
      if (accept) begin
        if (!mode_ok || (load_cnt == 5'd0)) begin
          state    <= IDLE;
          word_cnt <= 5'd0;
        end else begin
          state     <= SEND;
          buffer    <= rate_block;
          rem_bits  <= output_size;
          word_cnt  <= load_cnt;
          last_flag <= last_block;
        end
      end else if (send_hs) begin
        buffer   <= buffer << WORD_W;
        word_cnt <= word_cnt - 5'd1;
        rem_bits <= rem_full ? (rem_bits - 32'd64) : 32'd0;
        if (word_cnt == 5'd1) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_squeeze_serializer.sv
// Self-checking bench for squeeze_serializer: a word-level queue model built
// from block parameters, checked against every output handshake.
module tb_squeeze_serializer;

  localparam int RATE = 1344;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  bits;
    logic        last;
  } word_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            block_valid;
  logic            block_ready;
  logic [RATE-1:0] rate_block;
  logic [1:0]      operation_mode;
  logic [31:0]     output_size;
  logic            last_block;
  logic [63:0]     data_out;
  logic            data_out_valid;
  logic            data_out_ready;
  logic            data_out_last;
  logic [6:0]      data_out_bits;
  logic            mode_error;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int errCycle = -10;
  int errSeen = 0;
  int hsCount = 0;
  bit randomReady = 0;
  bit readyHold = 1;

  word_t       expQ[$];
  logic [63:0] logData[$];
  logic [6:0]  logBits[$];
  logic        logLast[$];
  int          logCycle[$];

  squeeze_serializer #(.WORD_W(64), .RATE_SHAKE128(RATE)) dut (
    .clk(clk),
    .rst(rst),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .rate_block(rate_block),
    .operation_mode(operation_mode),
    .output_size(output_size),
    .last_block(last_block),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_last(data_out_last),
    .data_out_bits(data_out_bits),
    .mode_error(mode_error)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Sink ready: either held or randomly toggled each cycle.
  initial forever begin
    @(negedge clk);
    data_out_ready = randomReady ? 1'($urandom_range(0, 1)) : readyHold;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RATE-1:0] makeRate(input logic [31:0] seed);
    logic [RATE-1:0] r;
    r = '0;
    for (int k = 0; k < 21; k++) r[RATE-1-64*k -: 64] = {32'hC0DE0000 | seed, 32'(k)};
    return r;
  endfunction

  // Model: the words a block must produce, from the mode/size/last rules.
  task automatic modelPush(input logic [1:0] mode, input logic [31:0] size,
                           input logic last, input logic [RATE-1:0] rate);
    longint rw, need, cnt, remain;
    word_t w;
    if (mode != 2'b00 && mode != 2'b01) begin
      errCycle = cycle + 1;
      return;
    end
    rw   = (mode == 2'b01) ? 17 : 21;
    need = (longint'(size) + 63) / 64;
    cnt  = (need < rw) ? need : rw;
    for (longint k = 0; k < cnt; k++) begin
      remain = longint'(size) - 64 * k;
      w.bits = (remain >= 64) ? 7'd64 : 7'(remain);
      w.data = rate[RATE-1-64*k -: 64];
      for (int b = 0; b < 64; b++) if ((63 - b) >= int'(w.bits)) w.data[b] = 1'b0;
      w.last = last && (k == cnt - 1);
      expQ.push_back(w);
    end
  endtask

  // Offer one block (caller is at a falling edge); hold it until accepted.
  task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] size,
                               input logic last, input logic [31:0] seed);
    bit accepted = 0;
    block_valid    = 1'b1;
    operation_mode = mode;
    output_size    = size;
    last_block     = last;
    rate_block     = makeRate(seed);
    for (int i = 0; i < 300; i++) begin
      #1;
      if (block_ready) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      errors++;
      checks++;
      $display("[TB] FAIL block_accept: got no block_ready expected acceptance");
    end else begin
      modelPush(mode, size, last, rate_block);
    end
    @(negedge clk);
    block_valid = 1'b0;
  endtask

  task automatic waitHs(input int target, input int limit);
    bit reached = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #3;
      if (hsCount >= target) begin
        reached = 1;
        break;
      end
    end
    if (!reached) begin
      errors++;
      checks++;
      $display("[TB] FAIL handshake_timeout: got %0d expected %0d", hsCount, target);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model queue.
  initial begin
    logic [63:0] pData;
    logic [6:0]  pBits;
    logic        pLast, pValid, pReady;
    word_t       e;
    pValid = 0;
    pReady = 0;
    pData  = '0;
    pBits  = '0;
    pLast  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        checkOutput("reset_outputs",
                    {data_out, 31'd0, data_out_bits, data_out_valid, data_out_last, block_ready},
                    64'd0);
        expQ.delete();
        pValid = 0;
        continue;
      end
      checkOutput("mode_error", 64'(mode_error), 64'(cycle == errCycle));
      if (mode_error) errSeen++;
      if (pValid && !pReady) begin
        checkOutput("stall_valid", 64'(data_out_valid), 64'd1);
        checkOutput("stall_data", data_out, pData);
        checkOutput("stall_bits_last", {data_out_bits, data_out_last}, {pBits, pLast});
      end
      if (!data_out_valid) begin
        checkOutput("idle_outputs", data_out | 64'(data_out_bits) | 64'(data_out_last), 64'd0);
      end else if (expQ.size() == 0) begin
        checkOutput("spurious_valid", 64'(data_out_valid), 64'd0);
      end else if (data_out_ready) begin
        e = expQ.pop_front();
        checkOutput("word_data", data_out, e.data);
        checkOutput("word_bits", 64'(data_out_bits), 64'(e.bits));
        checkOutput("word_last", 64'(data_out_last), 64'(e.last));
        logData.push_back(data_out);
        logBits.push_back(data_out_bits);
        logLast.push_back(data_out_last);
        logCycle.push_back(cycle);
        hsCount++;
      end
      pValid = data_out_valid;
      pReady = data_out_ready;
      pData  = data_out;
      pBits  = data_out_bits;
      pLast  = data_out_last;
    end
  end

  initial begin
    int base, base2, errBase;
    rst            = 1'b1;
    block_valid    = 1'b0;
    rate_block     = '0;
    operation_mode = 2'b00;
    output_size    = 32'd0;
    last_block     = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    checkOutput("ready_after_reset", {63'd0, block_ready}, 64'd1);
    checkOutput("valid_after_reset", {63'd0, data_out_valid}, 64'd0);

    // SHAKE128, 256 bits, last block, sink always ready.
    base = hsCount;
    @(negedge clk);
    applyStimulus(2'b00, 32'd256, 1'b1, 32'd1);
    waitHs(base + 4, 100);
    repeat (2) @(negedge clk);
    #3;
    checkOutput("t1_count", 64'(hsCount - base), 64'd4);
    checkOutput("t1_word0", logData[base], 64'hC0DE0001_00000000);
    checkOutput("t1_word3", logData[base+3], 64'hC0DE0001_00000003);
    checkOutput("t1_lasts", {logLast[base+2], logLast[base+3]}, 64'b01);
    checkOutput("t1_idle", {data_out_valid, block_ready}, 64'b01);

    // SHAKE256: 2000-bit then 912-bit block, streamed back-to-back.
    base = hsCount;
    @(negedge clk);
    applyStimulus(2'b01, 32'd2000, 1'b0, 32'd2);
    applyStimulus(2'b01, 32'd912, 1'b1, 32'd3);
    waitHs(base + 32, 200);
    repeat (2) @(negedge clk);
    #3;
    checkOutput("t2_count", 64'(hsCount - base), 64'd32);
    checkOutput("t2_no_bubble", 64'(logCycle[base+31] - logCycle[base]), 64'd31);
    checkOutput("t2_blk1_end", logData[base+16], 64'hC0DE0002_00000010);
    checkOutput("t2_blk2_start", logData[base+17], 64'hC0DE0003_00000000);
    checkOutput("t2_final_data", logData[base+31], 64'hC0DE0000_00000000);
    checkOutput("t2_final_bits", 64'(logBits[base+31]), 64'd16);
    checkOutput("t2_final_last", 64'(logLast[base+31]), 64'd1);

    // SHAKE128 full 21-word block with a randomly stalling sink.
    randomReady = 1;
    base = hsCount;
    @(negedge clk);
    applyStimulus(2'b00, 32'd1344, 1'b1, 32'd4);
    waitHs(base + 21, 600);
    randomReady = 0;
    repeat (2) @(negedge clk);
    #3;
    checkOutput("t3_count", 64'(hsCount - base), 64'd21);
    checkOutput("t3_word20", logData[base+20], 64'hC0DE0004_00000014);
    checkOutput("t3_last", 64'(logLast[base+20]), 64'd1);

    // Unsupported mode and zero-size blocks are dropped.
    base    = hsCount;
    errBase = errSeen;
    @(negedge clk);
    applyStimulus(2'b11, 32'd256, 1'b1, 32'd5);
    repeat (4) @(negedge clk);
    applyStimulus(2'b00, 32'd0, 1'b1, 32'd6);
    repeat (4) @(negedge clk);
    #3;
    checkOutput("t4_no_words", 64'(hsCount - base), 64'd0);
    checkOutput("t4_err_pulses", 64'(errSeen - errBase), 64'd1);

    // Reset after three of ten words, then a fresh block.
    base = hsCount;
    @(negedge clk);
    applyStimulus(2'b00, 32'd640, 1'b1, 32'd7);
    waitHs(base + 3, 100);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    checkOutput("t5_ready_after_rst", {data_out_valid, block_ready}, 64'b01);
    base2 = hsCount;
    checkOutput("t5_words_before_rst", 64'(base2 - base), 64'd3);
    @(negedge clk);
    applyStimulus(2'b00, 32'd128, 1'b1, 32'd8);
    waitHs(base2 + 2, 100);
    repeat (3) @(negedge clk);
    #3;
    checkOutput("t5_restart_word0", logData[base2], 64'hC0DE0008_00000000);
    checkOutput("t5_count", 64'(hsCount - base2), 64'd2);
    checkOutput("leftover_words", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/squeeze_serializer.md
SQUEEZE_SERIALIZER -- requirements
Module: squeeze_serializer

Interface
REQ-001 Parameter WORD_W, default 64, output word width in bits; only 64 is supported.
REQ-002 clk  in  1  single clock; every flop updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 block_valid  in  1  permute stage offers a squeezed rate block.
REQ-005 block_ready  out  1  serializer accepts the block; transfer occurs when block_valid && block_ready.
REQ-006 rate_block  in  RATE_SHAKE128  squeezed rate; word k = rate_block[RATE_SHAKE128-1-64k -: 64].
REQ-007 operation_mode  in  2  SHAKE256_MODE_VEC or SHAKE128_MODE_VEC, per keccak_pkg.
REQ-008 output_size  in  32  output bits still owed, counted at this block, before it is emitted.
REQ-009 last_block  in  1  this is the final block of the output.
REQ-010 data_out  out  64  output word.
REQ-011 data_out_valid  out  1  data_out holds a valid word.
REQ-012 data_out_ready  in  1  sink accepts the word; transfer occurs when valid && ready.
REQ-013 data_out_last  out  1  this is the final word of the message; qualified by data_out_valid.
REQ-014 data_out_bits  out  7  count of valid bits in data_out, from 1 to 64, MSB-aligned.
REQ-015 mode_error  out  1  one-cycle pulse when a block is accepted with an unsupported mode.

Function
REQ-016 FSM has two states, IDLE and SEND; IDLE is the reset state.
REQ-017 In IDLE, block_ready=1 and data_out_valid=0.
REQ-018 On block accept, the serializer captures rate_block into a shift buffer and captures last_block and the remaining-bit count.
REQ-019 On block accept, it loads word_cnt = min(rate_words, ceil(output_size/64)).
  - rate_words = 17 for SHAKE256 and 21 for SHAKE128.
  - word_cnt is 5 bits.
REQ-020 If the loaded word_cnt is 0, or the mode is unsupported, the block is dropped and the FSM stays in IDLE.
  - An unsupported mode also pulses mode_error on the next cycle.
REQ-021 Otherwise the FSM enters SEND on the next cycle; the first word is valid one cycle after the accept.
REQ-022 In SEND, data_out_valid=1 and data_out = buffer[top 64].
  - Each handshake shifts the buffer left by 64, decrements word_cnt, and subtracts 64 from the remaining bits, saturating at 0.
REQ-023 data_out, data_out_bits and data_out_last shall hold stable while valid && !ready.
REQ-024 For a word with remaining bits >= 64, data_out_bits = 64.
  - Otherwise data_out_bits = remaining bits, and the unused LSBs of data_out are zero.
REQ-025 data_out_last = 1 only on the final word (word_cnt == 1) of a block whose last_block = 1.
REQ-026 block_ready shall also assert in SEND during the cycle the final word handshakes, so back-to-back blocks stream with no bubble.
  - A block accepted in that cycle reloads the buffer, and SEND continues.
  - If no block is accepted in that cycle, the FSM returns to IDLE.
REQ-027 block_valid while in SEND before the final handshake is ignored; block_ready=0 in that case.
REQ-028 output_size is not cross-checked against last_block.
  - A block with last_block=0 whose words run out still returns to IDLE or reloads as normal.

Reset
REQ-029 While rst=1, at the next edge: FSM -> IDLE, word_cnt=0, buffer=0, mode_error=0.
REQ-030 Output values while rst is high:
  - data_out_valid = 0, data_out_last = 0, block_ready = 0 (gated by rst).
  - data_out = 0 and data_out_bits = 0 while not valid.
REQ-031 block_ready=1 in the first cycle after rst deasserts.
REQ-032 Reset mid-SEND discards the remaining words; no partial word is emitted afterwards.

Verification
REQ-033 SHAKE128 block, output_size=256, last_block=1, ready held high:
  - exactly 4 words, the top 256 bits of the rate in order;
  - bits=64 on every word; last on word 4 only; FSM back in IDLE.
REQ-034 SHAKE256 block, output_size=2000, last_block=0, then a second block with output_size=912, last_block=1:
  - 17 words from block 1 and 15 words from block 2;
  - the final word has bits=16, low 48 bits zero, and last=1;
  - no idle cycle between the blocks when block 2 is held valid.
REQ-035 data_out_ready toggled randomly during a 21-word SHAKE128 block:
  - every word is stable while stalled;
  - no word is lost or duplicated.
REQ-036 Block with operation_mode=2'b11, or with output_size=0:
  - accepted and dropped, with no data_out_valid;
  - mode_error pulses only for the bad-mode case.
REQ-037 rst asserted after 3 of 10 words:
  - valid drops the next cycle and block_ready=1 the cycle after rst deasserts;
  - a new block then starts at its word 0.
